div16s8_seq: RTL



---
 rtl/div16s8_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/div16s8_seq.sv
// Sequential 16/8 signed divider, radix-2 non-restoring on magnitudes.
// Define DIV16S8_ROUND_EN for round-to-nearest (ties away from zero).
module div16s8_seq #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero,
  output logic        ovf
);

  localparam int LAT   = 16 / ITER_PER_CYCLE + 2;
  localparam int NSTEP = LAT - 2;

  if (!(ITER_PER_CYCLE == 1 ||
        ITER_PER_CYCLE == 2 ||
        ITER_PER_CYCLE == 4)) begin : g_bad_ipc
    $error("ITER_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [15:0] r_q;
  logic [8:0]  r_p;
  logic [8:0]  r_d;
  logic        r_sn_a;
  logic        r_sn_b;
  logic        r_dz;
  logic        r_min_m1;
  logic [7:0]  r_dvd_lo;

  logic [15:0] w_amag;
  logic [8:0]  w_bext;
  logic [8:0]  w_bmag;

  logic [8:0]  w_p;
  logic [8:0]  w_sh;
  logic [15:0] w_q;
  logic [15:0] w_dvd;

  logic [15:0] w_qmag;
  logic [7:0]  w_rmag;
  logic [15:0] w_qs;
  logic [7:0]  w_rs;
  logic        w_up;

  always_comb begin
    w_amag = dividend[15] ? -dividend : dividend;
    w_bext = {divisor[7], divisor};
    w_bmag = divisor[7] ? -w_bext : w_bext;
  end

  // P stays in [-D, D): the 9-bit shift cannot overflow
  always_comb begin
    w_p   = r_p;
    w_q   = r_q;
    w_dvd = r_dvd;
    w_sh  = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      w_sh  = {w_p[7:0], w_dvd[15]};
      w_p   = w_p[8] ? w_sh + r_d : w_sh - r_d;
      w_q   = {w_q[14:0], ~w_p[8]};
      w_dvd = {w_dvd[14:0], 1'b0};
    end
  end

  always_comb begin
    w_qmag = r_q;
    w_rmag = r_p[8] ? 8'(r_p + r_d) : r_p[7:0];
    w_up   = 1'b0;
`ifdef DIV16S8_ROUND_EN
    w_up = ({w_rmag, 1'b0} >= r_d);
    if (w_up) begin
      w_qmag = r_q + 16'd1;
      w_rmag = w_rmag - r_d[7:0];
    end
`endif
    w_qs = (r_sn_a ^ r_sn_b) ? -w_qmag : w_qmag;
    w_rs = r_sn_a ? -w_rmag : w_rmag;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        if (r_cnt == 5'(NSTEP - 1))
          w_next = S_FIX;
      end
      S_FIX: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_q       <= '0;
      r_p       <= '0;
      r_d       <= '0;
      r_sn_a    <= 1'b0;
      r_sn_b    <= 1'b0;
      r_dz      <= 1'b0;
      r_min_m1  <= 1'b0;
      r_dvd_lo  <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd    <= w_amag;
            r_d      <= w_bmag;
            r_sn_a   <= dividend[15];
            r_sn_b   <= divisor[7];
            r_dz     <= (divisor == 8'h00);
            r_min_m1 <= (dividend == 16'h8000) &&
                        (divisor == 8'hFF);
            r_dvd_lo <= dividend[7:0];
            r_p      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_p   <= w_p;
          r_q   <= w_q;
          r_dvd <= w_dvd;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          if (r_dz) begin
            quotient  <= r_sn_a ? 16'h8000 : 16'h7FFF;
            remainder <= r_dvd_lo;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else if (r_min_m1) begin
            quotient  <= 16'h7FFF;
            remainder <= 8'h00;
            div_zero  <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= w_qs;
            remainder <= w_rs;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
